// File: rtl/pattern_recorder_pkg.sv
// Shared definitions for the live pattern recorder: recorder states and pattern geometry.
package pattern_recorder_pkg;

  localparam int STEPS = 8;      // steps per pattern
  localparam int N_INS = 4;      // instruments
  localparam int PAT_W = STEPS;  // one bit per step in a pattern word

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNT_IN = 2'd1,
    S_RECORD   = 2'd2,
    S_COMMIT   = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_recorder_tap_sync.sv
// tap_sync_edge: brings the raw asynchronous instrument keys into the clk domain
// and turns each press into a single-cycle event.
module tap_sync_edge
  import pattern_recorder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_INS-1:0] i_tap,
  output logic [N_INS-1:0] o_rise
);

  logic [N_INS-1:0] r_meta;
  logic [N_INS-1:0] r_sync;
  logic [N_INS-1:0] r_prev;

  // Two-flop synchronizer followed by a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_tap;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pattern_recorder.sv
// pattern_recorder: captures quantized drum taps over an 8-step count-in plus an
// 8-step record pass, then writes the four instrument patterns to the datapath.
module pattern_recorder
  import pattern_recorder_pkg::*;
#(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_tick,
  input  logic             arm,
  input  logic             cancel,
  input  logic             overdub,
  input  logic [N_INS-1:0] tap,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [1:0]       wr_sel,
  output logic [PAT_W-1:0] wr_data,
  output logic [2:0]       timing,
  output logic             recording,
  output logic             count_in,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_timing;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [PAT_W-1:0] r_cap    [N_INS];
  logic [PAT_W-1:0] r_shadow [N_INS];
  logic [1:0]       r_wsel;

  logic [N_INS-1:0] w_rise;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_phase;
  logic [2:0]       w_step;
  logic [2:0]       w_bit;
  logic             w_last;
  logic             w_accept;
  logic             w_capture_en;
  logic             w_arm_ok;

  tap_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_tap  (tap),
    .o_rise (w_rise)
  );

  // A tap coincident with step_tick belongs to the step that is just starting, at phase 0.
  assign w_last   = step_tick && (r_timing == 3'd7);
  assign w_accept = (r_state == S_COMMIT) && wr_ready;
  assign w_arm_ok = (r_state == S_IDLE) && arm;
  assign w_half   = r_period >> 1;
  assign w_phase  = step_tick ? '0 : r_cnt;
  assign w_step   = step_tick ? (r_timing + 3'd1) : r_timing;
  assign w_bit    = (w_phase < w_half) ? w_step : (w_step + 3'd1);
  // Capture during RECORD, including the tick that opens step 0 but not the tick that closes step 7.
  assign w_capture_en = !cancel &&
                        (((r_state == S_RECORD) && !w_last) ||
                         ((r_state == S_COUNT_IN) && w_last));

  // Phase counter (cycles since the last tick) and latched step period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_period <= '0;
    end else if (step_tick) begin
      r_period <= r_cnt;
      r_cnt    <= CNT_W'(1);
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; cancel outranks the end-of-pass tick, and COMMIT cannot be cancelled
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (arm) w_next = S_COUNT_IN;
      S_COUNT_IN: if (cancel) w_next = S_IDLE; else if (w_last) w_next = S_RECORD;
      S_RECORD:   if (cancel) w_next = S_IDLE; else if (w_last) w_next = S_COMMIT;
      S_COMMIT:   if (w_accept && (r_wsel == 2'd3)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Step index: zeroed by arm, advanced by ticks while counting in or recording
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_timing <= 3'd0;
    else if (w_arm_ok)
      r_timing <= 3'd0;
    else if (step_tick && ((r_state == S_COUNT_IN) || (r_state == S_RECORD)))
      r_timing <= r_timing + 3'd1;
  end

  // Write index walks ins1..ins4, advancing only on an accepted write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_wsel <= 2'd0;
    else if (r_state == S_IDLE) r_wsel <= 2'd0;
    else if (w_accept)          r_wsel <= r_wsel + 2'd1;
  end

  // Capture buffers seed on arm and accumulate taps; shadow takes them after the last write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_INS; i++) begin
        r_cap[i]    <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_INS; i++) begin
        if (w_arm_ok)
          r_cap[i] <= overdub ? r_shadow[i] : '0;
        else if (w_capture_en && w_rise[i])
          r_cap[i][w_bit] <= 1'b1;
      end
      if (w_accept && (r_wsel == 2'd3)) begin
        for (int i = 0; i < N_INS; i++) r_shadow[i] <= r_cap[i];
      end
    end
  end

  assign wr_valid  = (r_state == S_COMMIT);
  assign wr_sel    = wr_valid ? r_wsel : 2'd0;
  assign wr_data   = wr_valid ? r_cap[r_wsel] : '0;
  assign timing    = r_timing;
  assign count_in  = (r_state == S_COUNT_IN);
  assign recording = (r_state == S_COUNT_IN) || (r_state == S_RECORD);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pattern_recorder.sv
// Directed bench for pattern_recorder: step_tick every 100 clks, taps placed at
// chosen phases of chosen RECORD steps, commits compared against hand-derived patterns.
module tb_pattern_recorder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step_tick = 1'b0;
  logic       arm = 1'b0;
  logic       cancel = 1'b0;
  logic       overdub = 1'b0;
  logic [3:0] tap = 4'h0;
  logic       wr_ready = 1'b1;
  logic       wr_valid;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [2:0] timing;
  logic       recording;
  logic       count_in;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sh [4];   // expected committed patterns

  always #5 clk = ~clk;

  pattern_recorder dut (
    .clk       (clk),
    .reset     (reset),
    .step_tick (step_tick),
    .arm       (arm),
    .cancel    (cancel),
    .overdub   (overdub),
    .tap       (tap),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .timing    (timing),
    .recording (recording),
    .count_in  (count_in),
    .busy      (busy)
  );

  // Advance one clk; inputs change 1 ns after the edge, a tick every 100th cycle
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    step_tick = (cyc % 100 == 0);
  endtask

  // Arm at phase 50, optionally tap during count-in step 4, stop on the 8th tick cycle
  task automatic count_in_pass(input logic od, input logic [3:0] ci_tap);
    int n = 0;
    int guard = 0;
    while (cyc % 100 != 50) step();
    overdub = od;
    arm = 1'b1;
    step();
    arm = 1'b0;
    while (n < 8 && guard < 1000) begin
      tap = (n == 4 && (cyc % 100) >= 10 && (cyc % 100) < 14) ? ci_tap : 4'h0;
      step();
      guard++;
      if (step_tick) n++;
    end
    tap = 4'h0;
  endtask

  // Cycle o of RECORD; the tap rises 2 clks early so its event lands at phase ph[s] of step s
  task automatic record_steps(input logic [3:0] m [8], input int ph [8],
                              input int n_cyc, input int arm_at);
    for (int o = 0; o < n_cyc; o++) begin
      tap = 4'h0;
      for (int s = 0; s < 8; s++)
        if (o >= s * 100 + ph[s] - 2 && o < s * 100 + ph[s] + 2) tap = tap | m[s];
      arm = (o == arm_at);
      step();
    end
    tap = 4'h0;
    arm = 1'b0;
  endtask

  // Full pass with wr_ready high; returns the writes seen and clks from final tick to first wr_valid
  task automatic run_pass(input logic od, input logic [3:0] ci_tap, input int arm_at,
                          input logic [3:0] m [8], input int ph [8],
                          output logic [7:0] d [4], output logic [1:0] s [4],
                          output int n, output int lat);
    count_in_pass(od, ci_tap);
    record_steps(m, ph, 800, arm_at);
    n = 0;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      d[k] = 8'h00;
      s[k] = 2'd0;
    end
    while (!wr_valid && lat < 20) begin
      step();
      lat++;
    end
    for (int k = 0; k < 40 && n < 4; k++) begin
      if (wr_valid && wr_ready) begin
        d[n] = wr_data;
        s[n] = wr_sel;
        n++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if ({wr_valid, wr_sel, wr_data, timing, recording, count_in, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0",
               {wr_valid, wr_sel, wr_data, timing, recording, count_in, busy});
    end
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({wr_valid, wr_sel, wr_data, timing, recording, count_in, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h, expected 0",
               {wr_valid, wr_sel, wr_data, timing, recording, count_in, busy});
    end
    arm = 1'b1;
    step();
    arm = 1'b0;
    n_checks++;
    if ({recording, count_in, busy, timing} !== {1'b1, 1'b1, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL arm_count_in: got rec/cin/busy/timing=%b, expected 1110000",
               {recording, count_in, busy, timing});
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_checks++;
    if ({recording, count_in, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL cancel_count_in: got rec/cin/busy=%b, expected 000", {recording, count_in, busy});
    end
  endtask

  task automatic test_basic();
    logic [3:0] m [8] = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
    int         ph [8] = '{10, 0, 10, 0, 10, 0, 10, 0};
    logic [7:0] exp [4] = '{8'h55, 8'h00, 8'h00, 8'h00};
    logic [7:0] d [4];
    logic [1:0] s [4];
    int n, lat;
    run_pass(1'b0, 4'h0, -1, m, ph, d, s, n, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d clks, expected 1", lat);
    end
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes, expected 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s[k], d[k]} !== {2'(k), exp[k]}) begin
        n_fail++;
        $display("FAIL basic_write%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                 k, s[k], d[k], k, exp[k]);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_after: got busy=%b, expected 0", busy);
    end
    sh = exp;
  endtask

  task automatic test_late_wrap();
    logic [3:0] m [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
    int         ph [8];
    int         phases [3] = '{70, 49, 50};
    logic [7:0] want [3] = '{8'h01, 8'h80, 8'h01};
    logic [7:0] d [4];
    logic [1:0] s [4];
    int n, lat;
    for (int t = 0; t < 3; t++) begin
      ph = '{0, 0, 0, 0, 0, 0, 0, phases[t]};
      run_pass(1'b0, 4'h0, -1, m, ph, d, s, n, lat);
      n_checks++;
      if ({n, d[0], d[1], d[2], d[3]} !== {32'd4, 8'h00, 8'h00, 8'h00, want[t]}) begin
        n_fail++;
        $display("FAIL late_wrap_ph%0d: got n=%0d data=%h %h %h %h, expected n=4 data=00 00 00 %h",
                 phases[t], n, d[0], d[1], d[2], d[3], want[t]);
      end
    end
    sh = '{8'h00, 8'h00, 8'h00, 8'h01};
  endtask

  task automatic test_overdub();
    logic [3:0] ma [8] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] mb [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0};
    int         ph [8] = '{10, 10, 10, 10, 10, 0, 0, 0};
    logic [7:0] expa [4] = '{8'h00, 8'h0F, 8'h00, 8'h00};
    logic [7:0] expb [4] = '{8'h00, 8'h1F, 8'h00, 8'h00};
    logic [7:0] d [4];
    logic [1:0] s [4];
    int n, lat;
    run_pass(1'b0, 4'h0, -1, ma, ph, d, s, n, lat);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s[k], d[k]} !== {2'(k), expa[k]}) begin
        n_fail++;
        $display("FAIL overdub_seed%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                 k, s[k], d[k], k, expa[k]);
      end
    end
    run_pass(1'b1, 4'h0, -1, mb, ph, d, s, n, lat);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL overdub_count: got %0d writes, expected 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s[k], d[k]} !== {2'(k), expb[k]}) begin
        n_fail++;
        $display("FAIL overdub_write%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                 k, s[k], d[k], k, expb[k]);
      end
    end
    sh = expb;
  endtask

  task automatic test_handshake();
    logic [3:0] m [8] = '{default: 4'h0};
    int         ph [8] = '{default: 0};
    int         acc = 0;
    int         lat = 0;
    logic       stalled = 1'b0;
    count_in_pass(1'b1, 4'h0);
    record_steps(m, ph, 800, -1);
    while (!wr_valid && lat < 20) begin
      step();
      lat++;
    end
    for (int k = 0; k < 80 && acc < 4; k++) begin
      if (wr_valid && wr_sel == 2'd1 && !stalled) begin
        wr_ready = 1'b0;
        for (int j = 0; j < 20; j++) begin
          n_checks++;
          if ({wr_valid, wr_sel, wr_data} !== {1'b1, 2'd1, sh[1]}) begin
            n_fail++;
            $display("FAIL hs_stall_clk%0d: got v/sel/data=%b/%0d/%h, expected 1/1/%h",
                     j, wr_valid, wr_sel, wr_data, sh[1]);
          end
          step();
        end
        wr_ready = 1'b1;
        stalled = 1'b1;
      end
      if (wr_valid) begin
        n_checks++;
        if ({wr_sel, wr_data} !== {2'(acc), sh[acc]}) begin
          n_fail++;
          $display("FAIL hs_write%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                   acc, wr_sel, wr_data, acc, sh[acc]);
        end
        acc++;
      end
      step();
    end
    n_checks++;
    if ({acc, stalled, busy} !== {32'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hs_total: got accepts=%0d stalled=%b busy=%b, expected 4 1 0", acc, stalled, busy);
    end
  endtask

  task automatic test_cancel();
    logic [3:0] m [8] = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] z [8] = '{default: 4'h0};
    int         ph [8] = '{10, 10, 10, 0, 0, 0, 0, 0};
    logic [7:0] d [4];
    logic [1:0] s [4];
    logic       seen = 1'b0;
    int n, lat;
    count_in_pass(1'b0, 4'h0);
    record_steps(m, ph, 350, -1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    n_checks++;
    if ({busy, recording} !== 2'b00) begin
      n_fail++;
      $display("FAIL cancel_idle: got busy/rec=%b, expected 00", {busy, recording});
    end
    repeat (150) begin
      if (wr_valid) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_no_write: got wr_valid seen=%b, expected 0", seen);
    end
    run_pass(1'b1, 4'h0, -1, z, ph, d, s, n, lat);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s[k], d[k]} !== {2'(k), sh[k]}) begin
        n_fail++;
        $display("FAIL cancel_shadow%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                 k, s[k], d[k], k, sh[k]);
      end
    end
  endtask

  task automatic test_ignored();
    logic [3:0] m [8] = '{4'h0, 4'hA, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1, 4'h0};
    int         ph [8] = '{0, 90, 0, 0, 0, 0, 40, 0};
    logic [7:0] exp [4] = '{8'h40, 8'h04, 8'h08, 8'h04};
    logic [7:0] d [4];
    logic [1:0] s [4];
    int n, lat;
    run_pass(1'b0, 4'h1, 250, m, ph, d, s, n, lat);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL ignored_count: got %0d writes, expected 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s[k], d[k]} !== {2'(k), exp[k]}) begin
        n_fail++;
        $display("FAIL ignored_write%0d: got sel=%0d data=%h, expected sel=%0d data=%h",
                 k, s[k], d[k], k, exp[k]);
      end
    end
    sh = exp;
  endtask

  task automatic test_reset_mid_commit();
    logic [3:0] m [8] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] z [8] = '{default: 4'h0};
    int         ph [8] = '{10, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] d [4];
    logic [1:0] s [4];
    int n, lat;
    count_in_pass(1'b0, 4'h0);
    record_steps(m, ph, 800, -1);
    wr_ready = 1'b0;
    step();
    step();
    n_checks++;
    if ({wr_valid, wr_data} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL rst_pre_commit: got v/data=%b/%h, expected 1/01", wr_valid, wr_data);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_valid, wr_sel, wr_data, timing, recording, count_in, busy} !== 17'h0) begin
      n_fail++;
      $display("FAIL rst_mid_commit: got %h, expected 0",
               {wr_valid, wr_sel, wr_data, timing, recording, count_in, busy});
    end
    step();
    reset = 1'b1;
    wr_ready = 1'b1;
    step();
    run_pass(1'b1, 4'h0, -1, z, ph, d, s, n, lat);
    n_checks++;
    if ({n, d[0], d[1], d[2], d[3]} !== {32'd4, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_clears_shadow: got n=%0d data=%h %h %h %h, expected n=4 all 00",
               n, d[0], d[1], d[2], d[3]);
    end
    sh = '{default: 8'h00};
  endtask

  initial begin
    sh = '{default: 8'h00};
    test_reset();
    test_basic();
    test_late_wrap();
    test_overdub();
    test_handshake();
    test_cancel();
    test_ignored();
    test_reset_mid_commit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion by 2 ms, expected completion");
    $fatal(1, "timeout");
  end

endmodule
